// File: rtl/nvdla_rubik_dma_wr_arb_pkg.sv
// Shared constants and types for the RUBIK DMA write-request arbiter.
package nvdla_rubik_dma_wr_arb_pkg;

    localparam int ARB_PD_W     = 515;
    localparam int ARB_SIZE_LSB = 64;
    localparam int ARB_SIZE_W   = 13;
    localparam int ARB_MASK_LSB = 512;

    localparam logic PKT_CMD  = 1'b0;
    localparam logic PKT_DATA = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DATA = 1'b1
    } arb_state_e;

    // Number of 256-bit halves carried by a data beat.
    function automatic logic [1:0] half_cnt(input logic [1:0] mask);
        half_cnt = {1'b0, mask[0]} + {1'b0, mask[1]};
    endfunction

endpackage

// File: rtl/nvdla_rubik_wr_arb_rr.sv
// Two-way round-robin picker: rr_ptr breaks ties, a lone eligible requester always wins.
module nvdla_rubik_wr_arb_rr (
    input  logic [1:0] elig,
    input  logic       rr_ptr,
    output logic       gnt_vld,
    output logic       gnt_idx
);

    // Pick a winner among the eligible requesters.
    always_comb begin
        gnt_vld = |elig;
        gnt_idx = 1'b0;
        case (elig)
            2'b01:   gnt_idx = 1'b0;
            2'b10:   gnt_idx = 1'b1;
            2'b11:   gnt_idx = rr_ptr;
            default: gnt_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/nvdla_rubik_dma_wr_arb.sv
// Packet-atomic two-requester arbiter for the RUBIK DMA write-request port.
// Optional per-requester stall counters enabled by RUBIK_WR_ARB_PERF_CNT_EN.
module nvdla_rubik_dma_wr_arb
    import nvdla_rubik_dma_wr_arb_pkg::*;
#(
    parameter int PD_W     = ARB_PD_W,
    parameter int SIZE_LSB = ARB_SIZE_LSB,
    parameter int SIZE_W   = ARB_SIZE_W,
    parameter int MASK_LSB = ARB_MASK_LSB
) (
    input  logic            nvdla_core_clk,
    input  logic            nvdla_core_rstn,
    input  logic            req0_vld,
    output logic            req0_rdy,
    input  logic [PD_W-1:0] req0_pd,
    input  logic            req0_type,
    input  logic            req1_vld,
    output logic            req1_rdy,
    input  logic [PD_W-1:0] req1_pd,
    input  logic            req1_type,
    output logic            dma_wr_req_vld,
    input  logic            dma_wr_req_rdy,
    output logic [PD_W-1:0] dma_wr_req_pd,
    output logic            dma_wr_req_type,
    output logic            arb_owner,
    output logic            arb_busy,
    input  logic            err_clr,
    output logic            arb_err,
    output logic [31:0]     req0_stall_cnt,
    output logic [31:0]     req1_stall_cnt
);

    localparam logic [SIZE_W:0] REMAIN_ONE = {{SIZE_W{1'b0}}, 1'b1};

    arb_state_e        state_r;
    logic              rr_ptr_r;
    logic              owner_r;
    logic              type_r;
    logic              hold_vld_r;
    logic              hold_idx_r;
    logic              arb_err_r;
    logic [SIZE_W:0]   remain_r;

    logic [1:0]        elig_s;
    logic              gnt_vld_s;
    logic              gnt_idx_s;
    logic              sel_idx_s;
    logic              sel_vld_s;
    logic              cand_vld_s;
    logic              cand_type_s;
    logic [PD_W-1:0]   cand_pd_s;
    logic [1:0]        pcnt_s;
    logic              accept_s;
    logic              done_s;
    logic              err_evt_s;

    // Only command packets may compete for the port while idle.
    always_comb begin
        elig_s    = 2'b00;
        elig_s[0] = req0_vld & (req0_pd[PD_W-1] == PKT_CMD);
        elig_s[1] = req1_vld & (req1_pd[PD_W-1] == PKT_CMD);
    end

    nvdla_rubik_wr_arb_rr u_rr (
        .elig    (elig_s),
        .rr_ptr  (rr_ptr_r),
        .gnt_vld (gnt_vld_s),
        .gnt_idx (gnt_idx_s)
    );

    // A stalled idle grant keeps its winner until it is accepted or withdrawn.
    always_comb begin
        sel_idx_s = owner_r;
        if (state_r == ST_IDLE) begin
            if (hold_vld_r && elig_s[hold_idx_r]) begin
                sel_idx_s = hold_idx_r;
            end else begin
                sel_idx_s = gnt_idx_s;
            end
        end else begin
            sel_idx_s = owner_r;
        end
        cand_vld_s  = sel_idx_s ? req1_vld  : req0_vld;
        cand_pd_s   = sel_idx_s ? req1_pd   : req0_pd;
        cand_type_s = sel_idx_s ? req1_type : req0_type;
        pcnt_s      = half_cnt(cand_pd_s[MASK_LSB +: 2]);
        sel_vld_s   = 1'b0;
        err_evt_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                sel_vld_s = gnt_vld_s;
                err_evt_s = (req0_vld & (req0_pd[PD_W-1] == PKT_DATA)) |
                            (req1_vld & (req1_pd[PD_W-1] == PKT_DATA));
            end
            ST_DATA: begin
                sel_vld_s = cand_vld_s & (cand_pd_s[PD_W-1] == PKT_DATA);
                err_evt_s = (cand_vld_s & (cand_pd_s[PD_W-1] == PKT_CMD)) |
                            (sel_vld_s & dma_wr_req_rdy & (pcnt_s == 2'd0));
            end
            default: begin
                sel_vld_s = 1'b0;
                err_evt_s = 1'b0;
            end
        endcase
    end

    assign accept_s = sel_vld_s & dma_wr_req_rdy;
    assign done_s   = ({{(SIZE_W-1){1'b0}}, pcnt_s} >= remain_r);

    // Packet lock, remaining-halves tracking and sticky error.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_r    <= ST_IDLE;
            rr_ptr_r   <= 1'b0;
            owner_r    <= 1'b0;
            type_r     <= 1'b0;
            hold_vld_r <= 1'b0;
            hold_idx_r <= 1'b0;
            arb_err_r  <= 1'b0;
            remain_r   <= '0;
        end else begin
            arb_err_r <= err_evt_s | (arb_err_r & ~err_clr);
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        owner_r    <= sel_idx_s;
                        type_r     <= cand_type_s;
                        remain_r   <= {1'b0, cand_pd_s[SIZE_LSB +: SIZE_W]} + REMAIN_ONE;
                        state_r    <= ST_DATA;
                        hold_vld_r <= 1'b0;
                    end else begin
                        hold_vld_r <= sel_vld_s;
                        hold_idx_r <= sel_idx_s;
                    end
                end
                ST_DATA: begin
                    hold_vld_r <= 1'b0;
                    if (accept_s) begin
                        if (done_s) begin
                            state_r  <= ST_IDLE;
                            remain_r <= '0;
                            rr_ptr_r <= ~owner_r;
                        end else begin
                            remain_r <= remain_r - {{(SIZE_W-1){1'b0}}, pcnt_s};
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign dma_wr_req_vld  = sel_vld_s;
    assign dma_wr_req_pd   = sel_vld_s ? cand_pd_s : '0;
    assign dma_wr_req_type = (state_r == ST_DATA) ? type_r : (sel_vld_s & cand_type_s);
    assign req0_rdy        = accept_s & ~sel_idx_s;
    assign req1_rdy        = accept_s &  sel_idx_s;
    assign arb_owner       = ((state_r == ST_IDLE) && sel_vld_s) ? sel_idx_s : owner_r;
    assign arb_busy        = (state_r == ST_DATA);
    assign arb_err         = arb_err_r;

`ifdef RUBIK_WR_ARB_PERF_CNT_EN
    logic [31:0] stall0_r;
    logic [31:0] stall1_r;

    // Saturating stall counters, cleared together with the sticky error.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            stall0_r <= 32'h0;
            stall1_r <= 32'h0;
        end else if (err_clr) begin
            stall0_r <= 32'h0;
            stall1_r <= 32'h0;
        end else begin
            if (req0_vld && !req0_rdy && (stall0_r != 32'hFFFF_FFFF)) begin
                stall0_r <= stall0_r + 32'h1;
            end else begin
                stall0_r <= stall0_r;
            end
            if (req1_vld && !req1_rdy && (stall1_r != 32'hFFFF_FFFF)) begin
                stall1_r <= stall1_r + 32'h1;
            end else begin
                stall1_r <= stall1_r;
            end
        end
    end

    assign req0_stall_cnt = stall0_r;
    assign req1_stall_cnt = stall1_r;
`else
    assign req0_stall_cnt = 32'h0;
    assign req1_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_nvdla_rubik_dma_wr_arb.sv
// Self-checking bench for nvdla_rubik_dma_wr_arb: directed scenarios plus a
// randomized run against a packet-level reference model.
module tb_nvdla_rubik_dma_wr_arb;

    localparam int PD_W     = 515;
    localparam int SIZE_LSB = 64;
    localparam int SIZE_W   = 13;
    localparam int MASK_LSB = 512;
`ifdef RUBIK_WR_ARB_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic            clk;
    logic            rstn;
    logic            vld [2];
    logic [PD_W-1:0] pd  [2];
    logic            typ [2];
    logic            dma_rdy;
    logic            err_clr;
    logic            req0_rdy, req1_rdy, dma_vld, dma_type, arb_owner, arb_busy, arb_err;
    logic [PD_W-1:0] dma_pd;
    logic [31:0]     stall0, stall1;

    int errors = 0;
    int checks = 0;

    nvdla_rubik_dma_wr_arb dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .req0_vld        (vld[0]),
        .req0_rdy        (req0_rdy),
        .req0_pd         (pd[0]),
        .req0_type       (typ[0]),
        .req1_vld        (vld[1]),
        .req1_rdy        (req1_rdy),
        .req1_pd         (pd[1]),
        .req1_type       (typ[1]),
        .dma_wr_req_vld  (dma_vld),
        .dma_wr_req_rdy  (dma_rdy),
        .dma_wr_req_pd   (dma_pd),
        .dma_wr_req_type (dma_type),
        .arb_owner       (arb_owner),
        .arb_busy        (arb_busy),
        .err_clr         (err_clr),
        .arb_err         (arb_err),
        .req0_stall_cnt  (stall0),
        .req1_stall_cnt  (stall1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- packet builders ----------------
    function automatic logic [PD_W-1:0] rand_pd();
        logic [PD_W-1:0] p;
        for (int b = 0; b < PD_W; b++) p[b] = 1'($urandom_range(0, 1));
        return p;
    endfunction

    function automatic logic [PD_W-1:0] mk_cmd(input int size);
        logic [PD_W-1:0] p;
        p = rand_pd();
        p[PD_W-1] = 1'b0;
        p[SIZE_LSB +: SIZE_W] = SIZE_W'(size);
        return p;
    endfunction

    function automatic logic [PD_W-1:0] mk_data(input logic [1:0] mask);
        logic [PD_W-1:0] p;
        p = rand_pd();
        p[PD_W-1] = 1'b1;
        p[MASK_LSB +: 2] = mask;
        return p;
    endfunction

    // ---------------- timing helpers ----------------
    task automatic settle();
        @(negedge clk);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        vld[0] = 1'b0; vld[1] = 1'b0;
        pd[0] = '0; pd[1] = '0;
        typ[0] = 1'b0; typ[1] = 1'b0;
        dma_rdy = 1'b1;
        err_clr = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        idle_inputs();
        next();
        next();
        rstn = 1'b1;
        next();
    endtask

    // ---------------- reference model ----------------
    int              m_busy, m_owner, m_remain, m_rr, m_err, m_hv, m_hi, m_type;
    longint          m_stall [2];
    int              e_vld, e_sel, e_owner, e_type, e_evt;
    bit              e_rdy [2];
    logic [PD_W-1:0] e_pd;

    function automatic void model_reset();
        m_busy = 0; m_owner = 0; m_remain = 0; m_rr = 0; m_err = 0;
        m_hv = 0; m_hi = 0; m_type = 0;
        m_stall[0] = 0; m_stall[1] = 0;
    endfunction

    function automatic void model_eval();
        bit el [2];
        for (int i = 0; i < 2; i++) el[i] = vld[i] && (pd[i][PD_W-1] == 1'b0);
        e_rdy[0] = 0; e_rdy[1] = 0;
        e_vld = 0; e_sel = m_owner; e_evt = 0; e_type = 0; e_pd = '0; e_owner = m_owner;
        if (m_busy == 0) begin
            if (m_hv != 0 && el[m_hi]) begin e_vld = 1; e_sel = m_hi; end
            else if (el[0] && el[1])   begin e_vld = 1; e_sel = m_rr; end
            else if (el[0])            begin e_vld = 1; e_sel = 0; end
            else if (el[1])            begin e_vld = 1; e_sel = 1; end
            for (int i = 0; i < 2; i++) if (vld[i] && pd[i][PD_W-1]) e_evt = 1;
            if (e_vld != 0) begin e_owner = e_sel; e_type = int'(typ[e_sel]); end
        end else begin
            e_type = m_type;
            if (vld[m_owner]) begin
                if (pd[m_owner][PD_W-1]) e_vld = 1;
                else e_evt = 1;
            end
            if (e_vld != 0 && dma_rdy && pd[m_owner][MASK_LSB +: 2] == 2'b00) e_evt = 1;
        end
        if (e_vld != 0) begin e_pd = pd[e_sel]; e_rdy[e_sel] = dma_rdy; end
    endfunction

    function automatic void model_commit();
        int pc;
        for (int i = 0; i < 2; i++)
            if (vld[i] && !e_rdy[i] && m_stall[i] < 64'hFFFF_FFFF) m_stall[i]++;
        if (err_clr) begin m_stall[0] = 0; m_stall[1] = 0; end
        m_err = (e_evt != 0 || (m_err != 0 && !err_clr)) ? 1 : 0;
        if (m_busy == 0) begin
            if (e_vld != 0 && dma_rdy) begin
                m_busy = 1; m_owner = e_sel; m_type = int'(typ[e_sel]); m_hv = 0;
                m_remain = int'(pd[e_sel][SIZE_LSB +: SIZE_W]) + 1;
            end else begin
                m_hv = e_vld; m_hi = e_sel;
            end
        end else begin
            m_hv = 0;
            if (e_vld != 0 && dma_rdy) begin
                pc = int'(pd[e_sel][MASK_LSB]) + int'(pd[e_sel][MASK_LSB+1]);
                if (pc >= m_remain) begin
                    m_busy = 0; m_remain = 0; m_rr = 1 - m_owner;
                end else begin
                    m_remain -= pc;
                end
            end
        end
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rstn = 1'b0;
        idle_inputs();
        next();
        settle();
        checks++; if (dma_vld !== 1'b0) begin errors++; $display("FAIL rst_vld: got %0b exp 0", dma_vld); end
        checks++; if (dma_pd !== '0) begin errors++; $display("FAIL rst_pd: got %0h exp 0", dma_pd); end
        checks++; if (dma_type !== 1'b0) begin errors++; $display("FAIL rst_type: got %0b exp 0", dma_type); end
        checks++; if ({req0_rdy, req1_rdy} !== 2'b00) begin errors++; $display("FAIL rst_rdy: got %0b exp 00", {req0_rdy, req1_rdy}); end
        checks++; if ({arb_busy, arb_err, arb_owner} !== 3'b000) begin errors++; $display("FAIL rst_status: got %0b exp 000", {arb_busy, arb_err, arb_owner}); end
        checks++; if ({stall0, stall1} !== 64'h0) begin errors++; $display("FAIL rst_stall: got %0h exp 0", {stall0, stall1}); end
        next();
        rstn = 1'b1;
        next();
    endtask

    task automatic test_single();
        logic [PD_W-1:0] c, d;
        int busy_cycles;
        do_reset();
        busy_cycles = 0;
        c = mk_cmd(3);
        vld[0] = 1'b1; pd[0] = c; typ[0] = 1'b1;
        settle();
        checks++; if (dma_vld !== 1'b1 || req0_rdy !== 1'b1) begin errors++; $display("FAIL single_cmd_hs: got vld=%0b rdy=%0b exp 1 1", dma_vld, req0_rdy); end
        checks++; if (dma_pd !== c) begin errors++; $display("FAIL single_cmd_pd: got %0h exp %0h", dma_pd, c); end
        checks++; if (dma_type !== 1'b1 || arb_owner !== 1'b0) begin errors++; $display("FAIL single_cmd_sel: got type=%0b owner=%0b exp 1 0", dma_type, arb_owner); end
        for (int k = 0; k < 2; k++) begin
            next();
            d = mk_data(2'b11);
            pd[0] = d;
            settle();
            if (arb_busy === 1'b1) busy_cycles++;
            checks++; if (dma_pd !== d || req0_rdy !== 1'b1) begin errors++; $display("FAIL single_data%0d: got rdy=%0b pd=%0h exp 1 %0h", k, req0_rdy, dma_pd, d); end
        end
        next();
        vld[0] = 1'b0;
        settle();
        checks++; if (busy_cycles !== 2) begin errors++; $display("FAIL single_busy_cycles: got %0d exp 2", busy_cycles); end
        checks++; if (arb_busy !== 1'b0 || arb_err !== 1'b0 || dma_vld !== 1'b0) begin errors++; $display("FAIL single_end: got busy=%0b err=%0b vld=%0b exp 000", arb_busy, arb_err, dma_vld); end
    endtask

    task automatic test_round_robin();
        logic [PD_W-1:0] c0, c1;
        do_reset();
        c0 = mk_cmd(0); c1 = mk_cmd(0);
        vld[0] = 1'b1; pd[0] = c0; vld[1] = 1'b1; pd[1] = c1;
        settle();
        checks++; if ({req0_rdy, req1_rdy, arb_owner} !== 3'b100) begin errors++; $display("FAIL rr_first: got rdy0,rdy1,owner=%0b exp 100", {req0_rdy, req1_rdy, arb_owner}); end
        next();
        pd[0] = mk_data(2'b01);
        settle();
        checks++; if ({req0_rdy, req1_rdy, arb_busy} !== 3'b101) begin errors++; $display("FAIL rr_r0_data: got %0b exp 101", {req0_rdy, req1_rdy, arb_busy}); end
        next();
        vld[0] = 1'b0;
        settle();
        checks++; if ({req1_rdy, arb_owner, arb_busy} !== 3'b110 || dma_pd !== c1) begin errors++; $display("FAIL rr_second: got rdy1,owner,busy=%0b exp 110", {req1_rdy, arb_owner, arb_busy}); end
        next();
        pd[1] = mk_data(2'b10);
        settle();
        checks++; if (req1_rdy !== 1'b1) begin errors++; $display("FAIL rr_r1_data: got %0b exp 1", req1_rdy); end
        next();
        vld[0] = 1'b1; pd[0] = mk_cmd(1); pd[1] = mk_cmd(2);
        settle();
        checks++; if ({req0_rdy, req1_rdy, arb_owner} !== 3'b100) begin errors++; $display("FAIL rr_third: got %0b exp 100", {req0_rdy, req1_rdy, arb_owner}); end
    endtask

    task automatic test_lock();
        logic [PD_W-1:0] c1;
        do_reset();
        c1 = mk_cmd(0);
        vld[0] = 1'b1; pd[0] = mk_cmd(3);
        next();
        vld[1] = 1'b1; pd[1] = c1;
        for (int k = 0; k < 2; k++) begin
            pd[0] = mk_data(2'b11);
            settle();
            checks++; if ({req0_rdy, req1_rdy} !== 2'b10) begin errors++; $display("FAIL lock_beat%0d: got %0b exp 10", k, {req0_rdy, req1_rdy}); end
            next();
        end
        vld[0] = 1'b0;
        settle();
        checks++; if ({req1_rdy, arb_owner} !== 2'b11 || dma_pd !== c1) begin errors++; $display("FAIL lock_handover: got rdy1,owner=%0b exp 11", {req1_rdy, arb_owner}); end
    endtask

    task automatic test_backpressure();
        logic [PD_W-1:0] d;
        do_reset();
        vld[0] = 1'b1; pd[0] = mk_cmd(3);
        next();
        d = mk_data(2'b11);
        pd[0] = d; dma_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            settle();
            checks++; if (dma_vld !== 1'b1 || req0_rdy !== 1'b0 || dma_pd !== d) begin errors++; $display("FAIL bp_hold%0d: got vld=%0b rdy=%0b exp 1 0", k, dma_vld, req0_rdy); end
            next();
        end
        dma_rdy = 1'b1;
        settle();
        checks++; if (stall0 !== (PERF ? 32'd5 : 32'd0)) begin errors++; $display("FAIL bp_stall0: got %0d exp %0d", stall0, PERF ? 5 : 0); end
        next();
        pd[0] = mk_data(2'b11);
        settle();
        checks++; if (arb_busy !== 1'b1 || req0_rdy !== 1'b1) begin errors++; $display("FAIL bp_remain: got busy=%0b rdy=%0b exp 1 1", arb_busy, req0_rdy); end
        next();
        vld[0] = 1'b0;
        settle();
        checks++; if (arb_busy !== 1'b0) begin errors++; $display("FAIL bp_done: got %0b exp 0", arb_busy); end
    endtask

    task automatic test_errors();
        do_reset();
        vld[0] = 1'b1; pd[0] = mk_data(2'b11);
        settle();
        checks++; if (req0_rdy !== 1'b0 || dma_vld !== 1'b0) begin errors++; $display("FAIL err_idle_data: got rdy=%0b vld=%0b exp 0 0", req0_rdy, dma_vld); end
        next();
        vld[0] = 1'b0;
        settle();
        checks++; if (arb_err !== 1'b1) begin errors++; $display("FAIL err_set: got %0b exp 1", arb_err); end
        next();
        err_clr = 1'b1;
        next();
        err_clr = 1'b0;
        settle();
        checks++; if (arb_err !== 1'b0) begin errors++; $display("FAIL err_clr: got %0b exp 0", arb_err); end
        next();
        vld[0] = 1'b1; pd[0] = mk_cmd(1);
        next();
        pd[0] = mk_cmd(2);
        settle();
        checks++; if ({req0_rdy, dma_vld, arb_busy} !== 3'b001) begin errors++; $display("FAIL err_cmd_in_data: got %0b exp 001", {req0_rdy, dma_vld, arb_busy}); end
        next();
        pd[0] = mk_data(2'b00);
        settle();
        checks++; if (arb_err !== 1'b1 || req0_rdy !== 1'b1) begin errors++; $display("FAIL err_mask00: got err=%0b rdy=%0b exp 1 1", arb_err, req0_rdy); end
        next();
        pd[0] = mk_data(2'b01);
        settle();
        checks++; if (arb_busy !== 1'b1 || arb_err !== 1'b1) begin errors++; $display("FAIL err_mask00_remain: got busy=%0b err=%0b exp 1 1", arb_busy, arb_err); end
        next();
        pd[0] = mk_data(2'b10);
        settle();
        checks++; if (arb_busy !== 1'b1) begin errors++; $display("FAIL err_last_busy: got %0b exp 1", arb_busy); end
        next();
        pd[0] = mk_data(2'b11); err_clr = 1'b1;
        next();
        vld[0] = 1'b0; err_clr = 1'b0;
        settle();
        checks++; if ({arb_busy, arb_err} !== 2'b01) begin errors++; $display("FAIL err_clr_race: got busy,err=%0b exp 01", {arb_busy, arb_err}); end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        vld[0] = 1'b1; pd[0] = mk_cmd(5); typ[0] = 1'b1;
        next();
        pd[0] = mk_data(2'b01);
        rstn = 1'b0;
        settle();
        checks++; if ({arb_busy, dma_vld, req0_rdy, dma_type, arb_owner, arb_err} !== 6'b0) begin errors++; $display("FAIL rstmid_outputs: got %0b exp 000000", {arb_busy, dma_vld, req0_rdy, dma_type, arb_owner, arb_err}); end
        checks++; if (dma_pd !== '0) begin errors++; $display("FAIL rstmid_pd: got %0h exp 0", dma_pd); end
        next();
        rstn = 1'b1; vld[0] = 1'b0;
        vld[1] = 1'b1; pd[1] = mk_cmd(0); typ[1] = 1'b1;
        settle();
        checks++; if ({req1_rdy, arb_owner, dma_type} !== 3'b111) begin errors++; $display("FAIL rstmid_regrant: got %0b exp 111", {req1_rdy, arb_owner, dma_type}); end
        next();
        pd[1] = mk_data(2'b01);
        settle();
        checks++; if (arb_busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy: got %0b exp 1", arb_busy); end
    endtask

    task automatic test_max_size();
        do_reset();
        vld[0] = 1'b1; pd[0] = mk_cmd(8191);
        next();
        pd[0] = mk_data(2'b11);
        repeat (4095) next();
        settle();
        checks++; if (arb_busy !== 1'b1 || req0_rdy !== 1'b1) begin errors++; $display("FAIL max_last_beat: got busy=%0b rdy=%0b exp 1 1", arb_busy, req0_rdy); end
        next();
        vld[0] = 1'b0;
        settle();
        checks++; if (arb_busy !== 1'b0) begin errors++; $display("FAIL max_done: got %0b exp 0", arb_busy); end
    endtask

    task automatic test_random();
        int              pend [2];
        bit              have [2];
        logic [PD_W-1:0] item [2];
        logic            ityp [2];
        logic [1:0]      m;
        do_reset();
        model_reset();
        pend[0] = 0; pend[1] = 0; have[0] = 0; have[1] = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (!have[i] && $urandom_range(0, 3) != 0) begin
                    if (pend[i] == 0) begin
                        item[i] = mk_cmd(int'($urandom_range(0, 6)));
                    end else begin
                        m = 2'($urandom_range(1, 3));
                        item[i] = mk_data(m);
                    end
                    ityp[i] = 1'($urandom_range(0, 1));
                    have[i] = 1;
                end
                vld[i] = have[i] && ($urandom_range(0, 7) != 0);
                pd[i]  = have[i] ? item[i] : rand_pd();
                typ[i] = have[i] ? ityp[i] : 1'b0;
            end
            dma_rdy = ($urandom_range(0, 3) != 0);
            err_clr = ($urandom_range(0, 49) == 0);
            settle();
            model_eval();
            checks++; if (dma_vld !== 1'(e_vld)) begin errors++; $display("FAIL rnd_vld @%0d: got %0b exp %0d", cyc, dma_vld, e_vld); end
            checks++; if ({req0_rdy, req1_rdy} !== {e_rdy[0], e_rdy[1]}) begin errors++; $display("FAIL rnd_rdy @%0d: got %0b exp %0b%0b", cyc, {req0_rdy, req1_rdy}, e_rdy[0], e_rdy[1]); end
            checks++; if (dma_pd !== e_pd) begin errors++; $display("FAIL rnd_pd @%0d: got %0h exp %0h", cyc, dma_pd, e_pd); end
            checks++; if (dma_type !== 1'(e_type) || arb_owner !== 1'(e_owner)) begin errors++; $display("FAIL rnd_type_owner @%0d: got %0b %0b exp %0d %0d", cyc, dma_type, arb_owner, e_type, e_owner); end
            checks++; if (arb_busy !== 1'(m_busy) || arb_err !== 1'(m_err)) begin errors++; $display("FAIL rnd_busy_err @%0d: got %0b %0b exp %0d %0d", cyc, arb_busy, arb_err, m_busy, m_err); end
            checks++; if (stall0 !== 32'(PERF ? m_stall[0] : 0) || stall1 !== 32'(PERF ? m_stall[1] : 0)) begin errors++; $display("FAIL rnd_stall @%0d: got %0d %0d exp %0d %0d", cyc, stall0, stall1, PERF ? m_stall[0] : 0, PERF ? m_stall[1] : 0); end
            for (int i = 0; i < 2; i++) begin
                if (e_rdy[i]) begin
                    if (item[i][PD_W-1] == 1'b0) begin
                        pend[i] = int'(item[i][SIZE_LSB +: SIZE_W]) + 1;
                    end else begin
                        pend[i] -= int'(item[i][MASK_LSB]) + int'(item[i][MASK_LSB+1]);
                        if (pend[i] < 0) pend[i] = 0;
                    end
                    have[i] = 0;
                end
            end
            model_commit();
            next();
        end
        idle_inputs();
    endtask

    initial begin
        rstn = 1'b0;
        idle_inputs();
        next();
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_backpressure();
        test_errors();
        test_reset_mid_packet();
        test_max_size();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
